button_bank: RTL
================

# button_bank

Parametrised front-panel button controller: NUM_BTNS raw switch inputs, each debounced, classified as a short or long press, then arbitrated onto a single one-cycle event bus. It sits between the board pins and the preset/MIDI logic. It generalises the two-button selector with per-button hold detection, so a long press forces a save regardless of MIDI state.

## Interface
- NUM_BTNS, 4: number of buttons, 1..15.
- DEBOUNCE_CNT, 21: consecutive stable synchronised samples required to accept a level change; ≥1.
- LONG_PRESS_CNT, 2**20: cycles of accepted-pressed level before a long press fires; > DEBOUNCE_CNT.
- ACTIVE_LOW, 0: 1 = raw input low means pressed.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- btn  in  NUM_BTNS  raw asynchronous switch inputs; bit i = button i+1.
- midi_in_state  in  2  MIDI input FSM state; value MIDI_LEARN (2'd1) enables save on short press.
- btn_valid  out  1  one-cycle event strobe; reset 0.
- btn_index  out  $clog2(NUM_BTNS+1)  1-based button number while btn_valid=1, else 0; reset 0.
- btn_long  out  1  event is a long press; 0 when btn_valid=0; reset 0.
- save_mode  out  1  event requests a preset save; 0 when btn_valid=0; reset 0.

## Operation
- Per button: 2-FF synchroniser, polarity fix (ACTIVE_LOW), then a debouncer. The accepted level toggles when the synchronised level has differed from it for DEBOUNCE_CNT consecutive cycles. Any mismatch-free sample clears the counter. Accepted level resets to released.
- Per-button FSM (btn_state_t):
  - IDLE: on accepted press -> PRESSED, hold counter cleared.
  - PRESSED: hold counter increments, saturating at LONG_PRESS_CNT.
    - Accepted release before saturation -> raise short event, -> IDLE.
    - Counter reaches LONG_PRESS_CNT -> raise long event, -> HELD.
  - HELD: no further events. Accepted release -> IDLE silently.
- Arbitration: of all events raised in a cycle, the lowest-numbered button wins. Other simultaneous events are dropped and not queued. FSMs still advance normally.
- Output register, on a winning event:
  - btn_valid=1, btn_index=i+1.
  - btn_long=1 for a long event, 0 for a short event.
  - save_mode=1 for a long event; for a short event, save_mode=(midi_in_state==MIDI_LEARN), sampled in the event cycle.
- No event: all outputs 0.
- Reset (any time, including mid-press): synchronisers, counters, accepted levels, FSMs (IDLE) and outputs cleared immediately. A button held through reset release is re-detected as a fresh press after the normal debounce latency.

## Timing
- Short press, press edge to accepted press: 2 sync cycles plus DEBOUNCE_CNT stable cycles.
- Short press, release edge to btn_valid: 2 + DEBOUNCE_CNT + 1 cycles.
- Long press: btn_valid is asserted LONG_PRESS_CNT + 1 cycles after the accepted press, while the button is still held.
- Events from one button are at least DEBOUNCE_CNT cycles apart. btn_valid never stays high for two consecutive cycles from the same button.
- No handshake: consumers must sample on btn_valid. Events are not back-pressured.
- Counter widths: $clog2(DEBOUNCE_CNT+1) and $clog2(LONG_PRESS_CNT+1). Both saturate and never wrap.

## Structure
- button_pkg:
  - btn_state_t enum {IDLE, PRESSED, HELD}.
  - MIDI_LEARN = 2'd1.
  - Index-width helper function.
- Sub-module btn_debounce (parameters DEBOUNCE_CNT, ACTIVE_LOW): synchroniser, debounce counter and accepted level; outputs level, press pulse and release pulse. Instantiated NUM_BTNS times in a generate loop.
- Hold FSMs, priority arbiter and output register live in button_bank.

## Test plan
Bench parameters: NUM_BTNS=4, DEBOUNCE_CNT=4, LONG_PRESS_CNT=32.
- Reset: assert rst with btn=4'b1111 -> all outputs 0. Release reset, keep buttons held -> no event until accepted press. Releasing button 1 then gives btn_valid with btn_index=1 and btn_long=0, 2+4+1 cycles after release.
- Bounce: toggle btn[2] every 2 cycles for 20 cycles, then hold 10 cycles, then release -> exactly one event, btn_index=3, btn_long=0. With midi_in_state=2'd0, save_mode=0.
- Short press in learn mode: midi_in_state=2'd1, press and release btn[1] for 10 cycles -> btn_index=2, btn_long=0, save_mode=1 for one cycle.
- Long press: midi_in_state=2'd0, hold btn[3] for 60 cycles -> btn_valid with btn_index=4, btn_long=1, save_mode=1 exactly once while held. No event on release.
- Simultaneous: release btn[0] and btn[2] on the same cycle -> one event with btn_index=1. Button 3 event dropped. Next btn_valid only on a new press.
- Mid-press reset: assert rst while btn[1] is in PRESSED with hold counter at 20 -> outputs 0 immediately. After reset release, no long event until 32 full cycles past the re-accepted press.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the front-panel button controller.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    localparam logic [1:0] MIDI_LEARN = 2'd1;

    // Width of a 1-based button number, with 0 reserved for "no button".
    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, polarity fix and debounce counter.
// Press/release pulses are registered, one cycle after the accepted level moves.
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 21,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic RELEASED_RAW = ACTIVE_LOW;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, release_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample;

    assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Counter only runs while the sample disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= RELEASED_RAW;
            sync2_q   <= RELEASED_RAW;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_bank.sv
// Debounced button bank with short/long press classification and a
// lowest-index-wins arbiter onto a single registered event strobe.
module button_bank
    import button_pkg::*;
#(
    parameter int NUM_BTNS       = 4,
    parameter int DEBOUNCE_CNT   = 21,
    parameter int LONG_PRESS_CNT = 2**20,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BTNS-1:0]           btn,
    input  logic [1:0]                    midi_in_state,
    output logic                          btn_valid,
    output logic [idx_w(NUM_BTNS)-1:0]    btn_index,
    output logic                          btn_long,
    output logic                          save_mode
);

    localparam int IW = idx_w(NUM_BTNS);
    localparam int HW = $clog2(LONG_PRESS_CNT + 1);

    logic [NUM_BTNS-1:0] level, press, rel;
    logic [NUM_BTNS-1:0] short_ev, long_ev;

    genvar g;
    generate
        for (g = 0; g < NUM_BTNS; g++) begin : g_btn
            btn_state_t    state_q, state_d;
            logic [HW-1:0] hold_q, hold_d;
            logic          short_l, long_l;

            btn_debounce #(
                .DEBOUNCE_CNT (DEBOUNCE_CNT),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_db (
                .clk       (clk),
                .rst_n     (rst),
                .raw_i     (btn[g]),
                .level_o   (level[g]),
                .press_o   (press[g]),
                .release_o (rel[g])
            );

            always_comb begin
                state_d = state_q;
                hold_d  = hold_q;
                short_l = 1'b0;
                long_l  = 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (press[g]) begin
                            state_d = PRESSED;
                            hold_d  = '0;
                        end
                    end
                    PRESSED: begin
                        if (rel[g]) begin
                            short_l = 1'b1;
                            state_d = IDLE;
                        end else if (hold_q == HW'(LONG_PRESS_CNT - 1)) begin
                            long_l  = 1'b1;
                            state_d = HELD;
                            hold_d  = HW'(LONG_PRESS_CNT);
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    HELD: begin
                        // Release after a long press is swallowed.
                        if (!level[g]) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= IDLE;
                    hold_q  <= '0;
                end else begin
                    state_q <= state_d;
                    hold_q  <= hold_d;
                end
            end

            assign short_ev[g] = short_l;
            assign long_ev[g]  = long_l;
        end
    endgenerate

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          win_long;

    // Scan high to low so the lowest-numbered event is the last to win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_long  = 1'b0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (short_ev[i] | long_ev[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i + 1);
                win_long  = long_ev[i];
            end
        end
    end

    logic          valid_q, valid_d;
    logic [IW-1:0] index_q, index_d;
    logic          long_q, long_d;
    logic          save_q, save_d;

    always_comb begin
        valid_d = win_found;
        index_d = win_idx;
        long_d  = win_found & win_long;
        save_d  = win_found & (win_long | (midi_in_state == MIDI_LEARN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            index_q <= '0;
            long_q  <= 1'b0;
            save_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            index_q <= index_d;
            long_q  <= long_d;
            save_q  <= save_d;
        end
    end

    assign btn_valid = valid_q;
    assign btn_index = index_q;
    assign btn_long  = long_q;
    assign save_mode = save_q;

endmodule
